// File: rtl/megarom_pkg.sv
// Shared types for the MegaROM mapper: FSM states, slot page codes and the
// CPU-address to bank-register index mapping.
package megarom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRIVE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] PAGE1 = 2'b01;
    localparam logic [1:0] PAGE2 = 2'b10;
    localparam int NUM_BANKS = 4;

    // Only ADDR[15:13] matter; 8 KB windows at 4000h/6000h/8000h/A000h map to 0..3.
    function automatic logic [1:0] bank_index(input logic [2:0] addr_top, input logic is_16k);
        logic [1:0] idx;
        if (is_16k)
            idx = {1'b0, addr_top[2]};
        else
            idx = addr_top[1:0] - 2'b10;
        return idx;
    endfunction

endpackage

// File: rtl/megarom_mapper_if.sv
// MSX cartridge slot bus and the mapper configuration bundle driven by the
// configuration register block.
interface BUS_IF;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic [7:0]  DOUT;
    logic        SLTSL_n;
    logic        MERQ_n;
    logic        RD_n;
    logic        WR_n;
    logic        RESET_n;
    logic        BUSDIR_n;
    logic        WAIT_n;
    logic        INT_n;

    modport CARTRIDGE (
        input  ADDR, DIN, SLTSL_n, MERQ_n, RD_n, WR_n, RESET_n,
        output DOUT, BUSDIR_n, WAIT_n, INT_n
    );
    modport HOST (
        output ADDR, DIN, SLTSL_n, MERQ_n, RD_n, WR_n, RESET_n,
        input  DOUT, BUSDIR_n, WAIT_n, INT_n
    );
endinterface

interface MEGAROM_IF;
    logic [7:0]  BankRegInit [0:3];
    logic [15:0] BankRegAddr [0:3];
    logic [15:0] BankRegAddrMask;
    logic [7:0]  BankRegMask;
    logic        WriteProtect;
    logic        is_16k_bank;
    logic        CS1_Mask;
    logic        CS2_Mask;
    logic [31:0] MemoryTopAddr;

    modport DEVICE (
        input BankRegInit, BankRegAddr, BankRegAddrMask, BankRegMask,
              WriteProtect, is_16k_bank, CS1_Mask, CS2_Mask, MemoryTopAddr
    );
    modport HOST (
        output BankRegInit, BankRegAddr, BankRegAddrMask, BankRegMask,
               WriteProtect, is_16k_bank, CS1_Mask, CS2_Mask, MemoryTopAddr
    );
endinterface

// File: rtl/megarom_bank_regs.sv
// Four MegaROM bank registers: address-match hit detection, load on bank
// writes, and reload from BankRegInit on either reset.
module megarom_bank_regs
    import megarom_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_n,
    MEGAROM_IF.DEVICE        Megarom,
    input  logic             i_bus_reset_n,
    input  logic             i_we,
    input  logic             i_region,
    input  logic [15:0]      i_addr,
    input  logic [7:0]       i_din,
    output logic [7:0]       o_bank,
    output logic             o_hit
);

    logic [7:0] r_bank [0:NUM_BANKS-1];
    logic [NUM_BANKS-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            w_hit[i] = i_region &&
                (((i_addr ^ Megarom.BankRegAddr[i]) & ~Megarom.BankRegAddrMask) == 16'h0000);
    end

    // Every matching register loads, so overlapping decode windows alias.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < NUM_BANKS; i++)
                r_bank[i] <= Megarom.BankRegInit[i];
        end else if (!i_bus_reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++)
                r_bank[i] <= Megarom.BankRegInit[i];
        end else if (i_we) begin
            for (int i = 0; i < NUM_BANKS; i++)
                if (w_hit[i])
                    r_bank[i] <= i_din & ~Megarom.BankRegMask;
        end
    end

    assign o_hit  = |w_hit;
    assign o_bank = r_bank[bank_index(i_addr[15:13], Megarom.is_16k_bank)];

endmodule

// File: rtl/megarom_mapper.sv
// MSX MegaROM mapper: decodes slot accesses to 4000h-BFFFh and fetches through
// an external RAM req/ack port. Optional bus wait insertion: MEGAROM_MAPPER_WAIT_EN.
module megarom_mapper
    import megarom_pkg::*;
#(
    parameter int RAM_AW = 24
) (
    input  logic              CLK,
    input  logic              RESET_n,
    BUS_IF.CARTRIDGE          Bus,
    MEGAROM_IF.DEVICE         Megarom,
    output logic              RAM_REQ,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic [7:0]        RAM_WDATA,
    input  logic              RAM_ACK,
    input  logic [7:0]        RAM_RDATA,
    output state_t            o_dbg_state
);

    // RAM handshake: RAM_REQ rises with RAM_WE/RAM_ADDR/RAM_WDATA stable and is held
    // until a one-cycle RAM_ACK; RAM_RDATA is sampled only in that ACK cycle.
    state_t              r_state, w_state_nxt;
    logic                r_rd_n_prev, r_wr_n_prev;
    logic                r_ram_req, w_ram_req_nxt;
    logic                r_ram_we, w_ram_we_nxt;
    logic [RAM_AW-1:0]   r_ram_addr, w_ram_addr_nxt;
    logic [7:0]          r_ram_wdata, w_ram_wdata_nxt;
    logic [7:0]          r_dout, w_dout_nxt;
    logic                r_busdir_n, w_busdir_n_nxt;

    logic w_rd_n, w_wr_n, w_det_rd, w_det_wr;
    logic w_cs1, w_cs2, w_region, w_hit, w_idle;
    logic w_start_rd, w_start_wr, w_bank_we;
    logic [7:0]        w_bank;
    logic [21:0]       w_offset;
    logic [RAM_AW-1:0] w_ram_addr;

    assign w_rd_n   = Bus.SLTSL_n | Bus.MERQ_n | Bus.RD_n;
    assign w_wr_n   = Bus.SLTSL_n | Bus.MERQ_n | Bus.WR_n;
    assign w_det_rd = r_rd_n_prev & ~w_rd_n;
    assign w_det_wr = r_wr_n_prev & ~w_wr_n;

    assign w_cs1    = (Bus.ADDR[15:14] == PAGE1) & ~Megarom.CS1_Mask;
    assign w_cs2    = (Bus.ADDR[15:14] == PAGE2) & ~Megarom.CS2_Mask;
    assign w_region = w_cs1 | w_cs2;
    assign w_idle   = (r_state == IDLE) & Bus.RESET_n;

    // Reads win if both strobes fall together.
    assign w_start_rd = w_idle & w_det_rd & w_region;
    assign w_bank_we  = w_idle & w_det_wr & ~w_det_rd;
    assign w_start_wr = w_bank_we & w_region & ~w_hit & ~Megarom.WriteProtect;

    megarom_bank_regs u_bank_regs (
        .CLK           (CLK),
        .RESET_n       (RESET_n),
        .Megarom       (Megarom),
        .i_bus_reset_n (Bus.RESET_n),
        .i_we          (w_bank_we),
        .i_region      (w_region),
        .i_addr        (Bus.ADDR),
        .i_din         (Bus.DIN),
        .o_bank        (w_bank),
        .o_hit         (w_hit)
    );

    assign w_offset   = Megarom.is_16k_bank ? {w_bank, Bus.ADDR[13:0]}
                                            : {1'b0, w_bank, Bus.ADDR[12:0]};
    assign w_ram_addr = RAM_AW'(Megarom.MemoryTopAddr) + RAM_AW'(w_offset);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_rd_n_prev <= 1'b1;
            r_wr_n_prev <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_n_prev <= w_rd_n;
            r_wr_n_prev <= w_wr_n;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start_rd || w_start_wr) w_state_nxt = REQ;
            REQ: begin
                if (!Bus.RESET_n)
                    w_state_nxt = RAM_ACK ? IDLE : DRAIN;
                else if (RAM_ACK)
                    w_state_nxt = r_ram_we ? IDLE : DRIVE;
            end
            DRIVE: if (!Bus.RESET_n || w_rd_n) w_state_nxt = IDLE;
            DRAIN: if (RAM_ACK) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ram_req_nxt   = r_ram_req;
        w_ram_we_nxt    = r_ram_we;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_dout_nxt      = r_dout;
        w_busdir_n_nxt  = r_busdir_n;
        case (r_state)
            IDLE: begin
                if (w_start_rd) begin
                    w_ram_req_nxt  = 1'b1;
                    w_ram_we_nxt   = 1'b0;
                    w_ram_addr_nxt = w_ram_addr;
                end else if (w_start_wr) begin
                    w_ram_req_nxt   = 1'b1;
                    w_ram_we_nxt    = 1'b1;
                    w_ram_addr_nxt  = w_ram_addr;
                    w_ram_wdata_nxt = Bus.DIN;
                end
            end
            REQ: begin
                if (RAM_ACK) begin
                    w_ram_req_nxt = 1'b0;
                    if (Bus.RESET_n && !r_ram_we) begin
                        w_dout_nxt     = RAM_RDATA;
                        w_busdir_n_nxt = 1'b0;
                    end
                end
            end
            DRIVE: begin
                if (!Bus.RESET_n || w_rd_n) begin
                    w_dout_nxt     = 8'h00;
                    w_busdir_n_nxt = 1'b1;
                end
            end
            DRAIN: if (RAM_ACK) w_ram_req_nxt = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 8'h00;
            r_dout      <= 8'h00;
            r_busdir_n  <= 1'b1;
        end else begin
            r_ram_req   <= w_ram_req_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_dout      <= w_dout_nxt;
            r_busdir_n  <= w_busdir_n_nxt;
        end
    end

    assign RAM_REQ      = r_ram_req;
    assign RAM_WE       = r_ram_we;
    assign RAM_ADDR     = r_ram_addr;
    assign RAM_WDATA    = r_ram_wdata;
    assign Bus.DOUT     = r_dout;
    assign Bus.BUSDIR_n = r_busdir_n;
    assign Bus.INT_n    = 1'b1;
    assign o_dbg_state  = r_state;

`ifdef MEGAROM_MAPPER_WAIT_EN
    assign Bus.WAIT_n = ~((r_state == REQ) | w_start_rd | w_start_wr);
`else
    assign Bus.WAIT_n = 1'b1;
`endif

endmodule

// File: tb/tb_megarom_mapper.sv
// Directed bench for megarom_mapper: slot reads/writes, bank-register writes,
// 8 KB/16 KB mapping, write protect, region masking and slot-bus reset.
module tb_megarom_mapper;
    import megarom_pkg::*;

`ifdef MEGAROM_MAPPER_WAIT_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif
    localparam logic EXP_WAIT_BUSY = ~WAIT_EN;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        RAM_REQ, RAM_WE;
    logic [23:0] RAM_ADDR;
    logic [7:0]  RAM_WDATA;
    logic        RAM_ACK;
    logic [7:0]  RAM_RDATA;
    state_t      dbg_state;

    BUS_IF     bus();
    MEGAROM_IF mr();

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    always #5 CLK = ~CLK;

    megarom_mapper #(.RAM_AW(24)) dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .Bus         (bus),
        .Megarom     (mr),
        .RAM_REQ     (RAM_REQ),
        .RAM_WE      (RAM_WE),
        .RAM_ADDR    (RAM_ADDR),
        .RAM_WDATA   (RAM_WDATA),
        .RAM_ACK     (RAM_ACK),
        .RAM_RDATA   (RAM_RDATA),
        .o_dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic bus_idle();
        bus.SLTSL_n = 1'b1;
        bus.MERQ_n  = 1'b1;
        bus.RD_n    = 1'b1;
        bus.WR_n    = 1'b1;
    endtask

    // Full read cycle: request, RAM answers after 'delay' cycles, data driven until RD_n rises.
    task automatic bus_read(input string tag, input logic [15:0] addr,
                            input logic [23:0] exp_addr, input logic [7:0] rdata, input int delay);
        exp_q.push_back(32'(exp_addr));
        bus.ADDR = addr; bus.SLTSL_n = 1'b0; bus.MERQ_n = 1'b0; bus.RD_n = 1'b0;
        #1 chk({tag, ".wait_start"}, 32'(bus.WAIT_n), 32'(EXP_WAIT_BUSY));
        tick();
        chk({tag, ".req"}, 32'(RAM_REQ), 32'd1);
        chk({tag, ".we"}, 32'(RAM_WE), 32'd0);
        chk({tag, ".addr"}, 32'(RAM_ADDR), exp_q.pop_front());
        chk({tag, ".wait_req"}, 32'(bus.WAIT_n), 32'(EXP_WAIT_BUSY));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, ".req_hold"}, 32'(RAM_REQ), 32'd1);
        end
        RAM_ACK = 1'b1; RAM_RDATA = rdata;
        tick();
        RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
        chk({tag, ".dout"}, 32'(bus.DOUT), 32'(rdata));
        chk({tag, ".busdir"}, 32'(bus.BUSDIR_n), 32'd0);
        chk({tag, ".req_drop"}, 32'(RAM_REQ), 32'd0);
        chk({tag, ".wait_rel"}, 32'(bus.WAIT_n), 32'd1);
        tick();
        chk({tag, ".dout_hold"}, 32'(bus.DOUT), 32'(rdata));
        bus_idle();
        tick();
        chk({tag, ".busdir_rel"}, 32'(bus.BUSDIR_n), 32'd1);
        chk({tag, ".dout_rel"}, 32'(bus.DOUT), 32'd0);
        chk({tag, ".idle"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // Write that must reach RAM.
    task automatic bus_write_ram(input string tag, input logic [15:0] addr,
                                 input logic [7:0] data, input logic [23:0] exp_addr);
        bus.ADDR = addr; bus.DIN = data; bus.SLTSL_n = 1'b0; bus.MERQ_n = 1'b0; bus.WR_n = 1'b0;
        tick();
        chk({tag, ".req"}, 32'(RAM_REQ), 32'd1);
        chk({tag, ".we"}, 32'(RAM_WE), 32'd1);
        chk({tag, ".wdata"}, 32'(RAM_WDATA), 32'(data));
        chk({tag, ".addr"}, 32'(RAM_ADDR), 32'(exp_addr));
        RAM_ACK = 1'b1;
        tick();
        RAM_ACK = 1'b0;
        chk({tag, ".req_drop"}, 32'(RAM_REQ), 32'd0);
        chk({tag, ".idle"}, 32'(dbg_state), 32'(IDLE));
        bus_idle();
        tick();
    endtask

    // Access that must not reach RAM (bank hit, write protect, masked region).
    task automatic bus_no_ram(input string tag, input logic [15:0] addr,
                              input logic [7:0] data, input logic is_rd);
        bus.ADDR = addr; bus.DIN = data; bus.SLTSL_n = 1'b0; bus.MERQ_n = 1'b0;
        if (is_rd) bus.RD_n = 1'b0; else bus.WR_n = 1'b0;
        #1 chk({tag, ".wait"}, 32'(bus.WAIT_n), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk({tag, ".no_req"}, 32'(RAM_REQ), 32'd0);
            chk({tag, ".busdir"}, 32'(bus.BUSDIR_n), 32'd1);
            chk({tag, ".idle"}, 32'(dbg_state), 32'(IDLE));
        end
        bus_idle();
        tick();
    endtask

    initial begin
        RESET_n = 1'b0; RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
        bus_idle(); bus.ADDR = 16'h0000; bus.DIN = 8'h00; bus.RESET_n = 1'b1;
        mr.BankRegInit[0] = 8'h00; mr.BankRegInit[1] = 8'h01;
        mr.BankRegInit[2] = 8'h02; mr.BankRegInit[3] = 8'h03;
        mr.BankRegAddr[0] = 16'h0000; mr.BankRegAddr[1] = 16'h0000;
        mr.BankRegAddr[2] = 16'h9000; mr.BankRegAddr[3] = 16'h0000;
        mr.BankRegAddrMask = 16'h07FF; mr.BankRegMask = 8'h00;
        mr.WriteProtect = 1'b0; mr.is_16k_bank = 1'b0;
        mr.CS1_Mask = 1'b0; mr.CS2_Mask = 1'b0; mr.MemoryTopAddr = 32'h0010_0000;

        repeat (3) tick();
        chk("rst.req", 32'(RAM_REQ), 32'd0);
        chk("rst.we", 32'(RAM_WE), 32'd0);
        chk("rst.addr", 32'(RAM_ADDR), 32'd0);
        chk("rst.wdata", 32'(RAM_WDATA), 32'd0);
        chk("rst.busdir", 32'(bus.BUSDIR_n), 32'd1);
        chk("rst.dout", 32'(bus.DOUT), 32'd0);
        chk("rst.wait", 32'(bus.WAIT_n), 32'd1);
        chk("rst.int", 32'(bus.INT_n), 32'd1);
        chk("rst.state", 32'(dbg_state), 32'(IDLE));
        RESET_n = 1'b1;
        tick();

        // 8 KB mapping with initial banks {0,1,2,3}
        bus_read("rd6123", 16'h6123, 24'h102123, 8'h5A, 2);
        bus_read("rdA123", 16'hA123, 24'h106123, 8'hC3, 1);

        // Bank register write through the 9000h/07FFh window
        bus_no_ram("bankwr", 16'h9400, 8'h45, 1'b0);
        bus_read("rd8010", 16'h8010, 24'h18A010, 8'h33, 0);

        // 16 KB mode, bank[1] loaded with 03h through a 7000h window
        mr.is_16k_bank = 1'b1; mr.BankRegAddr[1] = 16'h7000;
        bus_no_ram("bankwr16", 16'h7000, 8'h03, 1'b0);
        bus_read("rdBFFF", 16'hBFFF, 24'h10FFFF, 8'h81, 1);
        bus_read("rd4001", 16'h4001, 24'h100001, 8'h18, 1);
        mr.is_16k_bank = 1'b0;

        // Write protect
        mr.WriteProtect = 1'b1;
        bus_no_ram("wp", 16'h4000, 8'hAA, 1'b0);
        mr.WriteProtect = 1'b0;
        bus_write_ram("wr4000", 16'h4000, 8'h77, 24'h100000);

        // Page 1 masked
        mr.CS1_Mask = 1'b1;
        bus_no_ram("cs1mask", 16'h4000, 8'h00, 1'b1);
        bus_read("rd8000", 16'h8000, 24'h18A000, 8'h66, 1);
        mr.CS1_Mask = 1'b0;

        // Slot-bus reset while the RAM request is outstanding
        bus.ADDR = 16'h6000; bus.SLTSL_n = 1'b0; bus.MERQ_n = 1'b0; bus.RD_n = 1'b0;
        tick();
        chk("brst.req", 32'(RAM_REQ), 32'd1);
        chk("brst.addr", 32'(RAM_ADDR), 32'h106000);
        bus.RESET_n = 1'b0;
        #1 chk("brst.wait_req", 32'(bus.WAIT_n), 32'(EXP_WAIT_BUSY));
        tick();
        bus.RESET_n = 1'b1;
        chk("brst.drain", 32'(dbg_state), 32'(DRAIN));
        chk("brst.wait_drain", 32'(bus.WAIT_n), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("brst.req_hold", 32'(RAM_REQ), 32'd1);
            chk("brst.busdir", 32'(bus.BUSDIR_n), 32'd1);
            tick();
        end
        RAM_ACK = 1'b1; RAM_RDATA = 8'hEE;
        tick();
        RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
        chk("brst.req_drop", 32'(RAM_REQ), 32'd0);
        chk("brst.dout", 32'(bus.DOUT), 32'd0);
        chk("brst.busdir_end", 32'(bus.BUSDIR_n), 32'd1);
        chk("brst.idle", 32'(dbg_state), 32'(IDLE));
        bus_idle();
        tick();
        bus_read("rd6000_rl", 16'h6000, 24'h102000, 8'h12, 1);
        bus_read("rd8000_rl", 16'h8000, 24'h104000, 8'h34, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
